// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring integer divider for the EX stage.
//
// Operands arrive 33 bits wide, already sign- or zero-extended, so a single
// signed datapath covers DIV/DIVU/REM/REMU. Magnitudes are divided
// unsigned over 32 restoring steps, then signs are applied in SIGN.
//
// Optional build macro: DIV_ZERO_BYPASS_EN
//   defined   - a zero divisor skips CALC and goes straight to SIGN
//   undefined - a zero divisor runs the full 32 CALC steps
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting; samples div_start and latches operand magnitudes
// CALC  | one restoring step per cycle, 32 cycles
// SIGN  | apply sign / divide-by-zero override, write result registers
// DONE  | div_done pulse; stall released so the pipeline advances
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH:0]   div_s1,
    input  logic [DATA_WIDTH:0]   div_s2,
    input  logic                  div_start,
    input  logic                  div_flush,
    output logic [DATA_WIDTH:0]   div_quotient,
    output logic [DATA_WIDTH:0]   div_remainder,
    output logic                  div_stall,
    output logic                  div_done
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

`ifdef DIV_ZERO_BYPASS_EN
    localparam bit ZERO_BYPASS = 1'b1;
`else
    localparam bit ZERO_BYPASS = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Operation context captured at acceptance
    logic          sign_q;
    logic          sign_r;
    logic          zero_div;
    logic [W:0]    s1_orig;
    logic [W-1:0]  dvs;

    // Restoring datapath: dvd shifts out dividend bits and shifts in quotient bits
    logic [W-1:0]  dvd;
    logic [W-1:0]  rem;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          s2_zero;
    logic [W-1:0]  mag_s1;
    logic [W-1:0]  mag_s2;

    logic [W:0]    shifted;
    logic          trial_ok;
    logic [W-1:0]  diff_lo;
    logic [W-1:0]  rem_nxt;
    logic [W-1:0]  dvd_nxt;

    logic [W:0]    q_ext;
    logic [W:0]    r_ext;
    logic [W:0]    q_final;
    logic [W:0]    r_final;

    assign accept  = div_start & ~div_flush;
    assign s2_zero = (div_s2 == '0);

    // Operand magnitudes; the negated low bits always fit because the
    // operands are 33-bit extensions of 32-bit values.
    assign mag_s1 = div_s1[W] ? (~div_s1[W-1:0] + W'(1)) : div_s1[W-1:0];
    assign mag_s2 = div_s2[W] ? (~div_s2[W-1:0] + W'(1)) : div_s2[W-1:0];

    // One restoring step. The partial remainder is always below dvs, so the
    // shifted value fits in W+1 bits and an accepted difference fits in W.
    assign shifted  = {rem, dvd[W-1]};
    assign trial_ok = (shifted >= {1'b0, dvs});
    assign diff_lo  = shifted[W-1:0] - dvs;
    assign rem_nxt  = trial_ok ? diff_lo : shifted[W-1:0];
    assign dvd_nxt  = {dvd[W-2:0], trial_ok};

    // Sign correction in W+1 bit two's complement; this also yields the
    // correct 0x8000_0000 quotient for the signed overflow case.
    assign q_ext   = {1'b0, dvd};
    assign r_ext   = {1'b0, rem};
    assign q_final = zero_div ? {(W+1){1'b1}} : (sign_q ? -q_ext : q_ext);
    assign r_final = zero_div ? s1_orig       : (sign_r ? -r_ext : r_ext);

    assign div_done  = (state == DONE);
    assign div_stall = div_start & (state != DONE) & ~div_flush;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a flush from any state returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (ZERO_BYPASS && s2_zero) begin
                        state_nxt = SIGN;
                    end else begin
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_nxt = SIGN;
                end
            end
            SIGN: begin
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (div_flush) begin
            state_nxt = IDLE;
        end
    end

    // Operand capture, iteration registers and step down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            zero_div <= 1'b0;
            s1_orig  <= '0;
            dvs      <= '0;
            dvd      <= '0;
            rem      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_q   <= div_s1[W] ^ div_s2[W];
                        sign_r   <= div_s1[W];
                        zero_div <= s2_zero;
                        s1_orig  <= div_s1;
                        dvs      <= mag_s2;
                        dvd      <= mag_s1;
                        rem      <= '0;
                        cnt      <= CW'(W - 1);
                    end
                end
                CALC: begin
                    dvd <= dvd_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt - CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers hold until the next unflushed SIGN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_quotient  <= '0;
            div_remainder <= '0;
        end else if (state == SIGN && !div_flush) begin
            div_quotient  <= q_final;
            div_remainder <= r_final;
        end
    end

endmodule
